// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the memory port sequencer slice.
//   mps_state_e   : sequencer state encoding (also exported on state_out)
//   MEM_READ_LAT  : default memory read latency in cycles
//   CNT_W         : width of the read-latency wait counter
//   GNT_FETCH/DATA: bit positions in the arbiter's one-hot grant vector
//   word_align()  : byte address -> word address (low two bits cleared)
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_WAIT = 2'd1,
    ST_WRITE     = 2'd2,
    ST_DONE      = 2'd3
  } mps_state_e;

  localparam int MEM_READ_LAT = 2;
  localparam int CNT_W        = 3;

  localparam int GNT_FETCH = 0;
  localparam int GNT_DATA  = 1;

  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return byte_addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_port_sequencer_if.sv
// ---------------------------------------------------------------------------
// mem_port_sequencer_if
// Bundles the two requester handshakes and the memory bus of the sequencer.
//   Requester side : fetch_req/fetch_addr, data_req/data_wr/data_addr/
//                    data_wdata in; fetch_done/data_done/rdata_out back.
//   Memory side    : mem_addr/mem_wr/mem_wdata out; mem_rdata back.
// Modports:
//   slave  - the sequencer (consumes requests, drives the memory bus)
//   master - the environment (requesters plus memory)
// ---------------------------------------------------------------------------
interface mem_port_sequencer_if;

  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        fetch_done;
  logic        data_done;
  logic [31:0] rdata_out;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_wr, data_addr, data_wdata,
    input  mem_rdata,
    output fetch_done, data_done, rdata_out,
    output mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, data_req, data_wr, data_addr, data_wdata,
    output mem_rdata,
    input  fetch_done, data_done, rdata_out,
    input  mem_addr, mem_wr, mem_wdata
  );

endinterface

// File: rtl/mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_rr_arbiter
// Two-requester round-robin arbiter with a one-hot grant.
//   Clk, Reset : clock, synchronous active-high reset
//   enable     : grant may only be issued while high (sequencer IDLE)
//   req_fetch  : fetch requester level
//   req_data   : data requester level
//   grant      : one-hot, bit GNT_FETCH / GNT_DATA; combinational
// On a tie the requester that was not granted last wins. The history
// register resets to "data", so fetch wins the first tie.
// ---------------------------------------------------------------------------
module mem_rr_arbiter
  import mips_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic       req_fetch,
  input  logic       req_data,
  output logic [1:0] grant
);

  logic last_data_reg;  // 1: data requester was granted most recently

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req_fetch && req_data) begin
        grant[GNT_FETCH] = last_data_reg;
        grant[GNT_DATA]  = ~last_data_reg;
      end else begin
        grant[GNT_FETCH] = req_fetch;
        grant[GNT_DATA]  = req_data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_data_reg <= 1'b1;
    end else if (grant[GNT_DATA]) begin
      last_data_reg <= 1'b1;
    end else if (grant[GNT_FETCH]) begin
      last_data_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_sequencer.sv
// ---------------------------------------------------------------------------
// mem_port_sequencer
// Serialises instruction-fetch and data (load/store) requests onto a single
// memory port with fixed read latency READ_LAT (1..7).
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : mem_port_sequencer_if.slave (requests, dones, memory bus)
//   busy       : high in every state except IDLE
//   state_out  : current state encoding (debug)
// Timing from grant cycle N: mem_addr valid from N+1; reads finish with the
// done pulse at N+READ_LAT+2, stores at N+2. One IDLE cycle always follows
// DONE, so a requester that drops req on its done is never re-granted.
// ---------------------------------------------------------------------------
module mem_port_sequencer
  import mips_pkg::*;
#(
  parameter int READ_LAT = MEM_READ_LAT
)
(
  input  logic                Clk,
  input  logic                Reset,
  mem_port_sequencer_if.slave bus,
  output logic                busy,
  output logic [1:0]          state_out
);

  if (READ_LAT < 1 || READ_LAT > 7) begin : g_bad_read_lat
    $error("mem_port_sequencer: READ_LAT must be within 1..7");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

  mps_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  // First READ_WAIT cycle is the one in which mem_addr reaches the memory;
  // the latency count only starts running after it.
  logic             issue_reg;
  logic             op_fetch_reg;
  logic [31:0]      mem_addr_reg;
  logic [31:0]      mem_wdata_reg;
  logic [31:0]      rdata_reg;
  logic             mem_wr_reg;
  logic             fetch_done_reg;
  logic             data_done_reg;
  logic [1:0]       grant;

  mem_rr_arbiter u_arb (
    .Clk       (Clk),
    .Reset     (Reset),
    .enable    (state_reg == ST_IDLE),
    .req_fetch (bus.fetch_req),
    .req_data  (bus.data_req),
    .grant     (grant)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      issue_reg      <= 1'b0;
      op_fetch_reg   <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      rdata_reg      <= '0;
      mem_wr_reg     <= 1'b0;
      fetch_done_reg <= 1'b0;
      data_done_reg  <= 1'b0;
    end else begin
      // Strobes are one-cycle unless explicitly re-asserted below.
      mem_wr_reg     <= 1'b0;
      fetch_done_reg <= 1'b0;
      data_done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant[GNT_FETCH]) begin
            op_fetch_reg <= 1'b1;
            mem_addr_reg <= word_align(bus.fetch_addr);
            cnt_reg      <= CNT_LOAD;
            issue_reg    <= 1'b1;
            state_reg    <= ST_READ_WAIT;
          end else if (grant[GNT_DATA]) begin
            op_fetch_reg <= 1'b0;
            mem_addr_reg <= word_align(bus.data_addr);
            if (bus.data_wr) begin
              mem_wr_reg    <= 1'b1;
              mem_wdata_reg <= bus.data_wdata;
              state_reg     <= ST_WRITE;
            end else begin
              cnt_reg   <= CNT_LOAD;
              issue_reg <= 1'b1;
              state_reg <= ST_READ_WAIT;
            end
          end
        end
        ST_READ_WAIT: begin
          if (issue_reg) begin
            issue_reg <= 1'b0;
          end else if (cnt_reg == '0) begin
            rdata_reg      <= bus.mem_rdata;
            fetch_done_reg <= op_fetch_reg;
            data_done_reg  <= ~op_fetch_reg;
            state_reg      <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_WRITE: begin
          data_done_reg <= 1'b1;
          state_reg     <= ST_DONE;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wr     = mem_wr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.rdata_out  = rdata_reg;
  assign bus.fetch_done = fetch_done_reg;
  assign bus.data_done  = data_done_reg;
  assign busy           = (state_reg != ST_IDLE);
  assign state_out      = state_reg;

endmodule

// File: doc/mem_port_sequencer.md
MEM_PORT_SEQUENCER -- requirements
Module: mem_port_sequencer

Interface
REQ-001 Parameter: READ_LAT, default 2, memory read latency in cycles (legal 1..7).
REQ-002 Port: Clk  in  1  single clock; all state updates on posedge Clk.
REQ-003 Port: Reset  in  1  synchronous, active-high reset.
REQ-004 Port: fetch_req  in  1  instruction-fetch request; level held until fetch_done.
REQ-005 Port: fetch_addr  in  32  fetch byte address.
REQ-006 Port: data_req  in  1  data-access request; level held until data_done.
REQ-007 Port: data_wr  in  1  1 = store, 0 = load; qualifies data_req.
REQ-008 Port: data_addr  in  32  data byte address.
REQ-009 Port: data_wdata  in  32  store data.
REQ-010 Port: mem_rdata  in  32  memory read data, valid READ_LAT cycles after address presented.
REQ-011 Port: mem_addr  out  32  registered word address to memory.
REQ-012 Port: mem_wr  out  1  registered memory write strobe (1 = write, 0 = read).
REQ-013 Port: mem_wdata  out  32  registered store data.
REQ-014 Port: fetch_done  out  1  one-cycle pulse, fetch complete, rdata_out valid.
REQ-015 Port: data_done  out  1  one-cycle pulse, data access complete; rdata_out valid for loads.
REQ-016 Port: rdata_out  out  32  captured read data; held until next capture.
REQ-017 Port: busy  out  1  1 in any state other than IDLE.
REQ-018 Port: state_out  out  2  current state encoding, for debug.

Function
REQ-019 States SHALL be IDLE=0, READ_WAIT=1, WRITE=2, DONE=3.
REQ-020 Requests SHALL be sampled only in IDLE; requests in other states SHALL wait, never be dropped.
REQ-021 Single request in IDLE SHALL be granted; simultaneous fetch_req and data_req SHALL be granted to the requester not granted last (round-robin); last_grant resets to data, so fetch wins the first tie.
REQ-022 On grant at cycle N, mem_addr SHALL equal {addr[31:2],2'b00} of the granted requester from cycle N+1 and stay stable until return to IDLE.
REQ-023 Fetch or load grant SHALL enter READ_WAIT with wait counter = READ_LAT-1; counter SHALL decrement each cycle; at counter 0 mem_rdata SHALL be captured into rdata_out and state SHALL go to DONE.
REQ-024 Store grant SHALL enter WRITE with mem_wr=1 and mem_wdata=data_wdata for exactly one cycle, then DONE.
REQ-025 In DONE the matching done output SHALL pulse high for exactly one cycle, then state SHALL return to IDLE.
REQ-026 Read completion latency SHALL be READ_LAT+2 cycles from grant cycle to done cycle; store latency SHALL be 2 cycles.
REQ-027 Minimum request-to-request spacing SHALL be one IDLE cycle after each DONE.
REQ-028 Requester dropping req before grant SHALL be treated as withdrawn; dropping req after grant SHALL NOT abort the access.
REQ-029 mem_wr SHALL be 0 in every state except WRITE.
REQ-030 fetch_done and data_done SHALL never be high in the same cycle.
REQ-031 Wait counter SHALL be 3 bits; READ_LAT outside 1..7 SHALL be an elaboration error.

Reset
REQ-032 Reset SHALL force state IDLE, counter 0, last_grant = data, mem_addr 0, mem_wr 0, mem_wdata 0, rdata_out 0, fetch_done 0, data_done 0, busy 0, state_out 0.
REQ-033 Reset mid-access SHALL abort with no done pulse; mem_wr SHALL be 0 in the cycle after Reset is sampled.
REQ-034 Reset SHALL take priority over every request in the same cycle.

Structure
REQ-035 State enum and default MEM_READ_LAT constant SHALL live in shared package mips_pkg.
REQ-036 Tie-break logic SHALL be sub-module mem_rr_arbiter (two requests, last_grant register, one-hot grant); FSM, counter and datapath registers stay in mem_port_sequencer.

Verification
REQ-037 READ_LAT=2, fetch_req with fetch_addr=0x0000_0007 -> mem_addr=0x0000_0004 from N+1, fetch_done at N+4, rdata_out = mem_rdata sampled at N+3.
REQ-038 Store data_addr=0x10, data_wdata=0xDEADBEEF -> mem_wr=1 only at N+1 with mem_wdata=0xDEADBEEF, data_done at N+2.
REQ-039 fetch_req and data_req (load) both high from reset, held -> fetch granted first, then data; second grant in first IDLE after fetch_done; no overlapping done.
REQ-040 Reset asserted during READ_WAIT of a load -> next cycle state_out=0, busy=0, no data_done; request still high is re-granted after Reset drops.
REQ-041 READ_LAT=1 and READ_LAT=7 back-to-back fetches -> done at N+3 and N+9 respectively; mem_addr stable throughout each access.
REQ-042 data_req pulsed one cycle while busy with fetch -> never granted, no data_done.
